acc_drain: RTL and testbench

ACC_DRAIN -- requirements
Module: acc_drain

---
 rtl/drain_pkg.sv | 17 +
 rtl/acc_drain.sv | 113 +++++++++++
 tb/tb_acc_drain.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/drain_pkg.sv
// Shared types and constants for the accumulator drain path and the PE array top.
package drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_STREAM  = 2'd2
  } drain_state_e;

  localparam int DRAIN_ACC_W = 32;

  // Index width for n PEs; a single PE still gets a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_drain.sv
// Snapshots all PE accumulators in one cycle (while the PEs clear) and streams them out with valid/ready.
// Optional build macro DRAIN_RELU_EN clamps negative words to zero on the output.
module acc_drain
  import drain_pkg::*;
#(
  parameter int N_PE  = 4,
  parameter int ACC_W = DRAIN_ACC_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [N_PE*ACC_W-1:0]      acc_in,
  output logic                       load_acc,
  output logic [ACC_W-1:0]           psum_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_data,
  output logic [idx_width(N_PE)-1:0] out_idx,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  localparam int               IDX_W    = idx_width(N_PE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PE - 1);

  drain_state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic [ACC_W-1:0] shadow_q [N_PE];
  logic             handshake;
  logic             at_last;
  logic [ACC_W-1:0] sel_word;
  logic [ACC_W-1:0] out_word;

  assign out_valid = (state_q == ST_STREAM);
  assign load_acc  = (state_q == ST_CAPTURE);
  assign busy      = (state_q != ST_IDLE);
  assign psum_out  = '0;
  assign handshake = out_valid & out_ready;
  assign at_last   = (idx_q == LAST_IDX);
  assign out_last  = out_valid & at_last;
  assign out_idx   = idx_q;
  assign done      = done_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = ST_STREAM;
        idx_d   = '0;
      end
      ST_STREAM: begin
        if (handshake) begin
          if (at_last) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Shadows latch on the same edge the PEs reload zero, so no product is lost or counted twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PE; i++) shadow_q[i] <= '0;
    end else if (state_q == ST_CAPTURE) begin
      for (int i = 0; i < N_PE; i++) shadow_q[i] <= acc_in[i*ACC_W +: ACC_W];
    end
  end

  generate
    if (N_PE == 1) begin : g_single
      assign sel_word = shadow_q[0];
    end else begin : g_multi
      assign sel_word = shadow_q[idx_q];
    end
  endgenerate

`ifdef DRAIN_RELU_EN
  assign out_word = sel_word[ACC_W-1] ? '0 : sel_word;
`else
  assign out_word = sel_word;
`endif

  assign out_data = out_valid ? out_word : '0;

endmodule

// File: tb/tb_acc_drain.sv
// Randomized and directed bench for acc_drain, checked against a queue-based transaction model.
module tb_acc_drain;

  localparam int N_PE  = 4;
  localparam int ACC_W = 32;
  localparam int IDX_W = (N_PE > 1) ? $clog2(N_PE) : 1;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic [N_PE*ACC_W-1:0] acc_in;
  logic                  load_acc;
  logic [ACC_W-1:0]      psum_out;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_W-1:0]      out_data;
  logic [IDX_W-1:0]      out_idx;
  logic                  out_last;
  logic                  busy;
  logic                  done;

  acc_drain #(.N_PE(N_PE), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .acc_in(acc_in),
    .load_acc(load_acc), .psum_out(psum_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Transaction model: a pending-capture flag, the queue of words still to deliver, and the done pulse.
  logic             capPending = 1'b0;
  logic [ACC_W-1:0] expQ [$];
  logic             expDone    = 1'b0;
  int               busyCnt    = 0;
  int               loadCnt    = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [ACC_W-1:0] expWord(input logic [ACC_W-1:0] w);
`ifdef DRAIN_RELU_EN
    return w[ACC_W-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  function automatic logic [N_PE*ACC_W-1:0] packWords(input logic [ACC_W-1:0] w0, w1, w2, w3);
    logic [N_PE*ACC_W-1:0] r;
    r = {w3, w2, w1, w0};
    return r;
  endfunction

  task automatic modelClear();
    capPending = 1'b0;
    expQ.delete();
    expDone = 1'b0;
  endtask

  task automatic modelUpdate();
    logic newDone;
    logic idle;
    newDone = 1'b0;
    idle    = !capPending && (expQ.size() == 0);
    if (idle && start) begin
      capPending = 1'b1;
    end else if (capPending) begin
      for (int i = 0; i < N_PE; i++) expQ.push_back(acc_in[i*ACC_W +: ACC_W]);
      capPending = 1'b0;
    end else if (expQ.size() > 0 && out_ready) begin
      void'(expQ.pop_front());
      if (expQ.size() == 0) newDone = 1'b1;
    end
    expDone = newDone;
  endtask

  task automatic checkAll();
    logic             v;
    logic [ACC_W-1:0] d;
    int               sz;
    sz = expQ.size();
    v  = (sz > 0);
    d  = v ? expWord(expQ[0]) : '0;
    checkOutput("out_valid", 64'(out_valid), 64'(v));
    checkOutput("out_data",  64'(out_data),  64'(d));
    checkOutput("out_idx",   64'(out_idx),   v ? 64'(N_PE - sz) : 64'(0));
    checkOutput("out_last",  64'(out_last),  64'(sz == 1));
    checkOutput("load_acc",  64'(load_acc),  64'(capPending));
    checkOutput("busy",      64'(busy),      64'(capPending || v));
    checkOutput("done",      64'(done),      64'(expDone));
    checkOutput("psum_out",  64'(psum_out),  64'(0));
    if (busy) busyCnt++;
    if (load_acc) loadCnt++;
  endtask

  // One clock: drive inputs just after the rising edge, check at the falling edge, advance the model.
  task automatic applyStimulus(input logic s, input logic r, input logic [N_PE*ACC_W-1:0] a);
    start     = s;
    out_ready = r;
    acc_in    = a;
    @(negedge clk);
    checkAll();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_async_busy",  64'(busy),      64'(0));
    modelClear();
    @(negedge clk);
    checkAll();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [N_PE*ACC_W-1:0] wA, wOnes, wNeg;

  initial begin
    wA    = packWords(32'd10, 32'd20, 32'd30, 32'd40);
    wOnes = packWords(32'd1, 32'd1, 32'd1, 32'd1);
    wNeg  = packWords(32'hFFFF_FFF6, 32'd5, 32'h8000_0000, 32'h7FFF_FFFF);
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; acc_in = '0;
    @(negedge clk);
    checkAll();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic drain with ready tied high; count busy and load cycles over the whole transaction.
    busyCnt = 0; loadCnt = 0;
    applyStimulus(1'b1, 1'b1, wA);
    for (int i = 0; i < N_PE + 3; i++) applyStimulus(1'b0, 1'b1, wA);
    checkOutput("busy_cycles", 64'(busyCnt), 64'(N_PE + 1));
    checkOutput("load_cycles", 64'(loadCnt), 64'(1));

    // Backpressure on idx 1, inputs change after capture, start ignored while busy, start in done cycle.
    applyStimulus(1'b1, 1'b1, wA);
    applyStimulus(1'b0, 1'b1, wA);
    applyStimulus(1'b0, 1'b1, wOnes);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, wOnes);
    applyStimulus(1'b0, 1'b1, wOnes);
    applyStimulus(1'b1, 1'b1, wOnes);
    applyStimulus(1'b0, 1'b1, wOnes);
    applyStimulus(1'b1, 1'b1, wA);
    for (int i = 0; i < N_PE + 2; i++) applyStimulus(1'b0, 1'b1, wA);

    // Reset in the middle of streaming, at idx 2.
    applyStimulus(1'b1, 1'b1, wA);
    applyStimulus(1'b0, 1'b1, wA);
    applyStimulus(1'b0, 1'b1, wA);
    applyStimulus(1'b0, 1'b1, wA);
    applyReset();
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, wA);

    // Negative accumulator words.
    applyStimulus(1'b1, 1'b1, wNeg);
    for (int i = 0; i < N_PE + 2; i++) applyStimulus(1'b0, 1'b1, wNeg);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [N_PE*ACC_W-1:0] a;
      for (int k = 0; k < N_PE; k++) a[k*ACC_W +: ACC_W] = $urandom();
      applyStimulus(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 65), a);
      if ($urandom_range(0, 199) == 0) applyReset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
